// File: rtl/dice_roll_sched_if.sv
// Host roll-request handshake between a host controller and dice_roll_sched.
//   host_req  : roll request level, held by the host until host_ack
//   host_die  : die code 0..6 (d4, d6, d8, d10, d12, d20, d100); 7 is invalid
//   host_spin : number of decrements to perform for this roll
//   host_ack  : one-cycle pulse, request accepted or rejected
//   host_err  : one-cycle pulse alongside host_ack when host_die is invalid
interface dice_roll_sched_if;
    logic       host_req;
    logic [2:0] host_die;
    logic [7:0] host_spin;
    logic       host_ack;
    logic       host_err;

    modport master (
        output host_req, host_die, host_spin,
        input  host_ack, host_err
    );

    modport slave (
        input  host_req, host_die, host_spin,
        output host_ack, host_err
    );
endinterface

// File: rtl/dice_roll_sched.sv
// Electronic dice roller. A roll starts from a held button (spins while the
// button stays down) or from a host request (spins a fixed number of cycles).
// The BCD result is then shown for TIMEOUT_TICKS tick pulses.
//   clk, rst     : clock, synchronous active-high reset
//   tick         : one-cycle 32 Hz pulse used for the display timeout
//   btn[6:0]     : die buttons d4, d6, d8, d10, d12, d20, d100 (lowest wins)
//   host         : host request handshake (slave side)
//   digit10/1    : BCD result, tens and units
//   show         : display enable, high only while the result is shown
//   busy         : high while spinning
//   result_valid : one-cycle pulse on entry to the show state
module dice_roll_sched #(
    parameter int TIMEOUT_TICKS = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [6:0]         btn,
    dice_roll_sched_if.slave   host,
    output logic [3:0]         digit10,
    output logic [3:0]         digit1,
    output logic               show,
    output logic               busy,
    output logic               result_valid
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SPIN_BTN  = 2'd1,
        SPIN_HOST = 2'd2,
        SHOW      = 2'd3
    } state_t;

    localparam logic [2:0] DIE_D100     = 3'd6;
    localparam logic [2:0] DIE_INVALID  = 3'd7;
    localparam logic [7:0] TIMEOUT_LOAD = 8'(TIMEOUT_TICKS);

    state_t     state_q, state_d;
    logic [2:0] die_q, die_d;
    logic [7:0] digits_q, digits_d;   // {tens, units} in BCD
    logic [7:0] spin_q, spin_d;
    logic [7:0] tmo_q, tmo_d;
    logic       ack_q, ack_d;
    logic       err_q, err_d;
    logic       rv_q, rv_d;

    // Starting (highest) face of each die, in BCD; d100 starts at 99.
    function automatic logic [7:0] load_value(input logic [2:0] die);
        case (die)
            3'd0:    load_value = 8'h04;
            3'd1:    load_value = 8'h06;
            3'd2:    load_value = 8'h08;
            3'd3:    load_value = 8'h10;
            3'd4:    load_value = 8'h12;
            3'd5:    load_value = 8'h20;
            default: load_value = 8'h99;
        endcase
    endfunction

    // One BCD step down with the die's wrap: 1 -> N, or 00 -> 99 for d100.
    function automatic logic [7:0] dec_value(input logic [2:0] die,
                                             input logic [7:0] bcd);
        if (die == DIE_D100 && bcd == 8'h00)
            dec_value = 8'h99;
        else if (die != DIE_D100 && bcd == 8'h01)
            dec_value = load_value(die);
        else if (bcd[3:0] == 4'd0)
            dec_value = {bcd[7:4] - 4'd1, 4'd9};
        else
            dec_value = {bcd[7:4], bcd[3:0] - 4'd1};
    endfunction

    function automatic logic [2:0] lowest_btn(input logic [6:0] b);
        lowest_btn = 3'd0;
        for (int i = 6; i >= 0; i--)
            if (b[i]) lowest_btn = 3'(i);
    endfunction

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            die_q    <= 3'd0;
            digits_q <= 8'h01;
            spin_q   <= 8'd0;
            tmo_q    <= 8'd0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            die_q    <= die_d;
            digits_q <= digits_d;
            spin_q   <= spin_d;
            tmo_q    <= tmo_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rv_q     <= rv_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        die_d    = die_q;
        digits_d = digits_q;
        spin_d   = spin_q;
        tmo_d    = tmo_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rv_d     = 1'b0;

        case (state_q)
            IDLE, SHOW: begin
                if (|btn) begin
                    state_d  = SPIN_BTN;
                    die_d    = lowest_btn(btn);
                    digits_d = load_value(lowest_btn(btn));
                // host_req is still high in the cycle host_ack is shown, so
                // the same request must not be taken twice.
                end else if (host.host_req && !ack_q) begin
                    ack_d = 1'b1;
                    if (host.host_die == DIE_INVALID) begin
                        err_d = 1'b1;
                    end else begin
                        die_d    = host.host_die;
                        digits_d = load_value(host.host_die);
                        spin_d   = host.host_spin;
                        if (host.host_spin == 8'd0) begin
                            state_d = SHOW;
                            rv_d    = 1'b1;
                            tmo_d   = TIMEOUT_LOAD;
                        end else begin
                            state_d = SPIN_HOST;
                        end
                    end
                end else if (state_q == SHOW) begin
                    // A zero load means a one-cycle display.
                    if (tmo_q == 8'd0) begin
                        state_d = IDLE;
                    end else if (tick) begin
                        tmo_d = tmo_q - 8'd1;
                        if (tmo_q == 8'd1) state_d = IDLE;
                    end
                end
            end
            SPIN_BTN: begin
                if (btn[die_q]) begin
                    digits_d = dec_value(die_q, digits_q);
                end else begin
                    state_d = SHOW;
                    rv_d    = 1'b1;
                    tmo_d   = TIMEOUT_LOAD;
                end
            end
            SPIN_HOST: begin
                digits_d = dec_value(die_q, digits_q);
                spin_d   = spin_q - 8'd1;
                if (spin_q == 8'd1) begin
                    state_d = SHOW;
                    rv_d    = 1'b1;
                    tmo_d   = TIMEOUT_LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign digit10       = digits_q[7:4];
    assign digit1        = digits_q[3:0];
    assign show          = (state_q == SHOW);
    assign busy          = (state_q == SPIN_BTN) || (state_q == SPIN_HOST);
    assign result_valid  = rv_q;
    assign host.host_ack = ack_q;
    assign host.host_err = err_q;

endmodule

// File: tb/tb_dice_roll_sched.sv
// Self-checking bench for dice_roll_sched. Main instance uses a 3-tick
// display timeout; a second instance with a zero timeout shares clk, rst,
// tick and btn and is used for the one-cycle display case.
module tb_dice_roll_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [6:0] btn;
    logic [3:0] digit10, digit1, digit10_z, digit1_z;
    logic       show, busy, result_valid;
    logic       show_z, busy_z, result_valid_z;
    logic [7:0] digits;

    int vectors    = 0;
    int miscompares = 0;

    dice_roll_sched_if hif ();
    dice_roll_sched_if hif_z ();

    dice_roll_sched #(.TIMEOUT_TICKS(3)) dut (
        .clk(clk), .rst(rst), .tick(tick), .btn(btn), .host(hif),
        .digit10(digit10), .digit1(digit1), .show(show), .busy(busy),
        .result_valid(result_valid)
    );

    dice_roll_sched #(.TIMEOUT_TICKS(0)) dut_z (
        .clk(clk), .rst(rst), .tick(tick), .btn(btn), .host(hif_z),
        .digit10(digit10_z), .digit1(digit1_z), .show(show_z), .busy(busy_z),
        .result_valid(result_valid_z)
    );

    assign digits = {digit10, digit1};

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Face shown after k decrements of a die started at its top face.
    // Regular dice live on 1..N; d100 lives on 0..99 (00 reads as 100).
    function automatic logic [7:0] model_face(input int d, input int k);
        int n, v;
        case (d)
            0: n = 4;
            1: n = 6;
            2: n = 8;
            3: n = 10;
            4: n = 12;
            5: n = 20;
            default: n = 100;
        endcase
        if (n == 100) v = (99 - (k % 100) + 100) % 100;
        else          v = ((n - 1 - (k % n)) + n) % n + 1;
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn = 7'd0;
        tick = 1'b0;
        hif.host_req = 1'b0;
        hif.host_die = 3'd0;
        hif.host_spin = 8'd0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (digits !== 8'h01) begin
            miscompares++; $display("FAIL reset_digits: got %h want 01", digits);
        end
        vectors++;
        if ({show, busy, result_valid, hif.host_ack, hif.host_err} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got show=%b busy=%b rv=%b ack=%b err=%b want all 0",
                     show, busy, result_valid, hif.host_ack, hif.host_err);
        end
    endtask

    task automatic test_btn_d6();
        logic [7:0] want [3] = '{8'h06, 8'h05, 8'h04};
        btn = 7'h02;
        for (int i = 0; i < 3; i++) begin
            cyc();
            vectors++;
            if (digits !== want[i] || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL d6_spin[%0d]: got digits=%h busy=%b want %h busy=1",
                         i, digits, busy, want[i]);
            end
        end
        btn = 7'd0;
        cyc();
        vectors++;
        if (digits !== 8'h04 || show !== 1'b1 || result_valid !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL d6_show: got digits=%h show=%b rv=%b busy=%b want 04 1 1 0",
                     digits, show, result_valid, busy);
        end
        cyc();
        vectors++;
        if (result_valid !== 1'b0 || show !== 1'b1) begin
            miscompares++;
            $display("FAIL d6_rv_once: got rv=%b show=%b want rv=0 show=1", result_valid, show);
        end
    endtask

    // Random button rolls; each new press starts from SHOW of the previous one.
    task automatic test_btn_random();
        for (int it = 0; it < 8; it++) begin
            int d, h;
            logic [6:0] upper;
            d = $urandom_range(0, 6);
            h = $urandom_range(1, 30);
            upper = 7'h7f << (d + 1);
            btn = 7'(1 << d) | (7'($urandom) & upper);
            cyc();
            vectors++;
            if (digits !== model_face(d, 0) || busy !== 1'b1 || show !== 1'b0) begin
                miscompares++;
                $display("FAIL btn_accept d=%0d: got digits=%h busy=%b show=%b want %h 1 0",
                         d, digits, busy, show, model_face(d, 0));
            end
            for (int i = 1; i < h; i++) begin
                btn = 7'(1 << d) | 7'($urandom);
                cyc();
                vectors++;
                if (digits !== model_face(d, i)) begin
                    miscompares++;
                    $display("FAIL btn_spin d=%0d i=%0d: got %h want %h",
                             d, i, digits, model_face(d, i));
                end
            end
            btn = 7'd0;
            cyc();
            vectors++;
            if (digits !== model_face(d, h - 1) || show !== 1'b1 || result_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL btn_result d=%0d h=%0d: got digits=%h show=%b rv=%b want %h 1 1",
                         d, h, digits, show, result_valid, model_face(d, h - 1));
            end
        end
    endtask

    task automatic host_roll(input int d, input int s);
        int n, acks;
        hif.host_req = 1'b1;
        hif.host_die = 3'(d);
        hif.host_spin = 8'(s);
        cyc();
        vectors++;
        if (hif.host_ack !== 1'b1 || hif.host_err !== 1'b0) begin
            miscompares++;
            $display("FAIL host_ack d=%0d s=%0d: got ack=%b err=%b want 1 0",
                     d, s, hif.host_ack, hif.host_err);
        end
        hif.host_req = 1'b0;
        if (s == 0) begin
            vectors++;
            if (digits !== model_face(d, 0) || show !== 1'b1 || result_valid !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL host_spin0 d=%0d: got digits=%h show=%b rv=%b busy=%b want %h 1 1 0",
                         d, digits, show, result_valid, busy, model_face(d, 0));
            end
            cyc();
            vectors++;
            if (hif.host_ack !== 1'b0 || result_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL host_spin0_pulse: got ack=%b rv=%b want 0 0", hif.host_ack, result_valid);
            end
        end else begin
            n = 0;
            acks = 1;
            while (busy === 1'b1 && n < 400) begin
                n++;
                cyc();
                if (hif.host_ack === 1'b1) acks++;
            end
            vectors++;
            if (n !== s || acks !== 1) begin
                miscompares++;
                $display("FAIL host_busy d=%0d: got %0d busy cycles %0d acks want %0d busy 1 ack",
                         d, n, acks, s);
            end
            vectors++;
            if (digits !== model_face(d, s) || show !== 1'b1 || result_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL host_result d=%0d s=%0d: got digits=%h show=%b rv=%b want %h 1 1",
                         d, s, digits, show, result_valid, model_face(d, s));
            end
        end
    endtask

    task automatic test_host();
        host_roll(5, 25);
        host_roll(6, 1);
        host_roll(6, 100);
        host_roll(6, 0);
        for (int it = 0; it < 6; it++)
            host_roll($urandom_range(0, 6), $urandom_range(0, 60));
    endtask

    task automatic test_arbitration();
        do_reset();
        btn = 7'h41;
        hif.host_req = 1'b1;
        hif.host_die = 3'd2;
        hif.host_spin = 8'd3;
        cyc();
        vectors++;
        if (digits !== 8'h04 || busy !== 1'b1 || hif.host_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL arb_accept: got digits=%h busy=%b ack=%b want 04 1 0",
                     digits, busy, hif.host_ack);
        end
        cyc();
        vectors++;
        if (digits !== 8'h03 || hif.host_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL arb_spin: got digits=%h ack=%b want 03 0", digits, hif.host_ack);
        end
        btn = 7'd0;
        cyc();
        vectors++;
        if (show !== 1'b1 || digits !== 8'h03 || hif.host_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL arb_show: got show=%b digits=%h ack=%b want 1 03 0",
                     show, digits, hif.host_ack);
        end
        cyc();
        vectors++;
        if (hif.host_ack !== 1'b1 || busy !== 1'b1 || show !== 1'b0 || digits !== 8'h08) begin
            miscompares++;
            $display("FAIL arb_host_late: got ack=%b busy=%b show=%b digits=%h want 1 1 0 08",
                     hif.host_ack, busy, show, digits);
        end
        hif.host_req = 1'b0;
        for (int i = 0; i < 20 && show !== 1'b1; i++) cyc();
        vectors++;
        if (show !== 1'b1 || digits !== model_face(2, 3)) begin
            miscompares++;
            $display("FAIL arb_host_result: got show=%b digits=%h want 1 %h",
                     show, digits, model_face(2, 3));
        end
    endtask

    // Runs from SHOW: an invalid die must be rejected without disturbing it.
    task automatic test_invalid();
        logic [7:0] held;
        held = digits;
        hif.host_req = 1'b1;
        hif.host_die = 3'd7;
        hif.host_spin = 8'd9;
        cyc();
        vectors++;
        if (hif.host_ack !== 1'b1 || hif.host_err !== 1'b1 || show !== 1'b1 ||
            busy !== 1'b0 || digits !== held) begin
            miscompares++;
            $display("FAIL invalid_die: got ack=%b err=%b show=%b busy=%b digits=%h want 1 1 1 0 %h",
                     hif.host_ack, hif.host_err, show, busy, digits, held);
        end
        hif.host_req = 1'b0;
        cyc();
        vectors++;
        if (hif.host_ack !== 1'b0 || hif.host_err !== 1'b0 || show !== 1'b1) begin
            miscompares++;
            $display("FAIL invalid_pulse: got ack=%b err=%b show=%b want 0 0 1",
                     hif.host_ack, hif.host_err, show);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        btn = 7'h01;
        cyc();
        cyc();
        btn = 7'd0;
        tick = 1'b1;  // coincides with the SHOW entry edge and must be ignored
        cyc();
        tick = 1'b0;
        vectors++;
        if (show !== 1'b1 || result_valid !== 1'b1 || show_z !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_entry: got show=%b rv=%b show_z=%b want 1 1 1",
                     show, result_valid, show_z);
        end
        for (int t = 1; t <= 3; t++) begin
            cyc();
            if (t == 1) begin
                vectors++;
                if (show_z !== 1'b0) begin
                    miscompares++;
                    $display("FAIL timeout_zero: got show_z=%b want 0", show_z);
                end
            end
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            vectors++;
            if (show !== (t < 3)) begin
                miscompares++;
                $display("FAIL timeout_tick%0d: got show=%b want %b", t, show, (t < 3));
            end
        end
        cyc();
        cyc();
        vectors++;
        if (show !== 1'b0 || busy !== 1'b0 || digits !== model_face(0, 1)) begin
            miscompares++;
            $display("FAIL timeout_idle: got show=%b busy=%b digits=%h want 0 0 %h",
                     show, busy, digits, model_face(0, 1));
        end
    endtask

    task automatic test_reset_mid_spin();
        do_reset();
        hif.host_req = 1'b1;
        hif.host_die = 3'd5;
        hif.host_spin = 8'd200;
        cyc();
        hif.host_req = 1'b0;
        cyc();
        cyc();
        hif.host_req = 1'b1;
        hif.host_die = 3'd3;
        hif.host_spin = 8'd5;
        rst = 1'b1;
        cyc();
        vectors++;
        if (busy !== 1'b0 || show !== 1'b0 || digits !== 8'h01 ||
            hif.host_ack !== 1'b0 || result_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_spin: got busy=%b show=%b digits=%h ack=%b rv=%b want 0 0 01 0 0",
                     busy, show, digits, hif.host_ack, result_valid);
        end
        cyc();
        vectors++;
        if (hif.host_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_ack: got ack=%b want 0", hif.host_ack);
        end
        rst = 1'b0;
        cyc();
        vectors++;
        if (hif.host_ack !== 1'b1 || busy !== 1'b1 || digits !== 8'h10) begin
            miscompares++;
            $display("FAIL reset_first_accept: got ack=%b busy=%b digits=%h want 1 1 10",
                     hif.host_ack, busy, digits);
        end
        hif.host_req = 1'b0;
    endtask

    initial begin
        hif_z.host_req = 1'b0;
        hif_z.host_die = 3'd0;
        hif_z.host_spin = 8'd0;
        test_reset();
        test_btn_d6();
        test_btn_random();
        test_host();
        test_arbitration();
        test_invalid();
        test_timeout();
        test_reset_mid_spin();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dice_roll_sched.md
DICE_ROLL_SCHED -- requirements
Module: dice_roll_sched

Interface
- REQ-001: Parameter TIMEOUT_TICKS, default 255: number of tick pulses the result stays displayed.
- REQ-002: clk  input  1  system clock; all state updates on rising edge.
- REQ-003: rst  input  1  reset; synchronous and active-high.
- REQ-004: tick  input  1  one-cycle pulse at 32 Hz from the shared prescaler.
- REQ-005: btn  input  7  debounced button levels, active-high; bit0..6 = d4, d6, d8, d10, d12, d20, d100.
- REQ-006: host_req  input  1  host roll request level; held until host_ack.
- REQ-007: host_die  input  3  host die code; 0..6 map as btn bits; 7 is invalid.
- REQ-008: host_spin  input  8  number of decrements for a host roll.
- REQ-009: host_ack  output  1  one-cycle pulse; host request accepted or rejected.
- REQ-010: host_err  output  1  one-cycle pulse with host_ack when host_die = 7.
- REQ-011: digit10, digit1  output  4 each  BCD result, tens and units.
- REQ-012: show  output  1  display enable.
- REQ-013: busy  output  1  high in SPIN_BTN or SPIN_HOST.
- REQ-014: result_valid  output  1  one-cycle pulse on entry to SHOW.

Function
- REQ-015: States are IDLE, SPIN_BTN, SPIN_HOST, and SHOW; the current die code is held in an internal 3-bit register.
- REQ-016: Die range: d4..d20 count N..1 and wrap 1 -> N; d100 counts 99..0 and wraps 0 -> 99, where 00 represents 100.
- REQ-017: Load value is N (4, 6, 8, 10, 12, 20) or 99 for d100, written as BCD into digit10/digit1.
- REQ-018: Decrement is BCD: units 0 -> 9 with tens borrow; die wrap per REQ-016 is applied in the same cycle.
- REQ-019: Arbitration in IDLE or SHOW: any btn high beats host_req; among buttons, the lowest index wins.
- REQ-020: A host_req that loses arbitration is left pending and is not acked.
- REQ-021: Button accept: at the edge, state becomes SPIN_BTN, the die register latches the winner, and digits load N; no decrement occurs on that edge.
- REQ-022: SPIN_BTN: on each edge where the latched button is still high, perform one decrement; all other buttons and host_req are ignored.
- REQ-023: SPIN_BTN exit: on the first edge where the latched button is low, go to SHOW with no decrement.
- REQ-024: Host accept (valid die): host_ack pulses, the die latches host_die, digits load N, an 8-bit spin counter loads host_spin, and state becomes SPIN_HOST.
- REQ-025: SPIN_HOST: each cycle, decrement once and decrement the spin counter; when the counter reaches 0, go to SHOW.
- REQ-026: host_spin = 0: go directly to SHOW at the accept edge with digits = N.
- REQ-027: host_die = 7: host_ack and host_err pulse together, and state and digits are unchanged.
- REQ-028: On SHOW entry: show = 1, result_valid pulses, and the 8-bit timeout counter loads TIMEOUT_TICKS.
- REQ-029: In SHOW, each tick decrements the timeout counter; when tick arrives with the counter at 1, go to IDLE and clear show.
- REQ-030: In SHOW, a new accept per REQ-019 leaves SHOW immediately, and show falls on the same edge.
- REQ-031: TIMEOUT_TICKS = 0 makes SHOW last exactly one cycle, then IDLE.
- REQ-032: show = 0 in every state except SHOW; busy = 1 only in SPIN_BTN and SPIN_HOST.
- REQ-033: Digits hold their value in IDLE and SHOW.
- REQ-034: If tick and a state exit coincide, the state exit takes priority.

Reset
- REQ-035: While rst is high at an edge: state = IDLE, digit10 = 0, digit1 = 1, show = 0, busy = 0.
- REQ-036: While rst is high at an edge: host_ack, host_err, and result_valid = 0; spin and timeout counters = 0.
- REQ-037: Reset mid-spin or mid-show takes effect on that edge, and a pending host_req is not acked.
- REQ-038: After reset deasserts, the first accept follows REQ-019.

Verification
- REQ-039: btn[1] (d6) high for 3 edges, then low -> digits 6, 5, 4; SHOW with 04; result_valid pulses once.
- REQ-040: host_req with die 5 (d20) and spin 25 -> host_ack once; 25 busy cycles; SHOW with 15.
- REQ-041: btn[0] and btn[6] rise with host_req in the same IDLE cycle -> d4 wins; host is acked only after return to IDLE/SHOW and btn is low.
- REQ-042: host_die 6 (d100) with spin 1 -> SHOW with 98; with spin 100 -> SHOW with 99; with spin 0 -> SHOW with 99 at the accept edge.
- REQ-043: TIMEOUT_TICKS = 3, SHOW entered -> show falls on the 3rd tick edge; host_die 7 -> host_ack and host_err together, with state unchanged.
- REQ-044: rst asserted during SPIN_HOST -> next cycle is IDLE, with 01, show = 0, busy = 0, and no host_ack.
